// File: rtl/adder_acc_n_bit.sv
// Chunk-serial adder/subtractor with accumulate: adds one CHUNK-bit slice per clock,
// LSB slice first, and publishes out/cout/ovf with a one-cycle done pulse.
module adder_acc_n_bit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, s_r;
    logic             c_r;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] slice_a, slice_b, slice_s;
    logic             slice_c, cin_msb, last;
    logic [WIDTH-1:0] sum_nx;

    always_comb begin
        slice_a            = a_r[idx*CHUNK +: CHUNK];
        slice_b            = b_r[idx*CHUNK +: CHUNK];
        {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, c_r};
        sum_nx                      = s_r;
        sum_nx[idx*CHUNK +: CHUNK]  = slice_s;
        // Carry into the MSB recovered from the MSB sum bit; only used on the last slice.
        cin_msb = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ sum_nx[WIDTH-1];
        last    = (idx == IW'(NCH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            c_r   <= 1'b0;
            idx   <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1; the +1 rides in as the first carry.
                        a_r   <= acc ? out : in_a;
                        b_r   <= sub ? ~in_b : in_b;
                        c_r   <= sub;
                        s_r   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_r <= sum_nx;
                    c_r <= slice_c;
                    if (last) begin
                        out   <= sum_nx;
                        cout  <= slice_c;
                        ovf   <= slice_c ^ cin_msb;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_acc_n_bit.sv
// Directed bench for adder_acc_n_bit: default 8/4 instance plus 4/1 and 8/8 sweep instances.
module tb_adder_acc_n_bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance, WIDTH=8 CHUNK=4
    logic       start = 0, sub = 0, acc = 0;
    logic [7:0] in_a = 0, in_b = 0, out;
    logic       cout, ovf, busy, done;

    // WIDTH=4 CHUNK=1
    logic       s4_start = 0;
    logic [3:0] s4_a = 0, s4_b = 0, s4_out;
    logic       s4_cout, s4_ovf, s4_busy, s4_done;

    // WIDTH=8 CHUNK=8
    logic       s8_start = 0;
    logic [7:0] s8_a = 0, s8_b = 0, s8_out;
    logic       s8_cout, s8_ovf, s8_busy, s8_done;

    adder_acc_n_bit #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .acc(acc),
        .in_a(in_a), .in_b(in_b), .out(out), .cout(cout), .ovf(ovf),
        .busy(busy), .done(done));

    adder_acc_n_bit #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .sub(1'b0), .acc(1'b0),
        .in_a(s4_a), .in_b(s4_b), .out(s4_out), .cout(s4_cout), .ovf(s4_ovf),
        .busy(s4_busy), .done(s4_done));

    adder_acc_n_bit #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .sub(1'b0), .acc(1'b0),
        .in_a(s8_a), .in_b(s8_b), .out(s8_out), .cout(s8_cout), .ovf(s8_ovf),
        .busy(s8_busy), .done(s8_done));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input string tag, input logic [7:0] eo, input logic ec, input logic ev);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".out"},  32'(out),  32'(eo));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"},  32'(ovf),  32'(ev));
    endtask

    // Launch one op on the default instance; returns just after the capture edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ac);
        in_a = a; in_b = b; sub = s; acc = ac; start = 1;
        tick();
        start = 0; in_a = 8'hxx; in_b = 8'hxx;
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("rst.out",  32'(out),  32'h00);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf",  32'(ovf),  32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        rst = 0;
        tick();

        // 3 + 4: busy from capture edge, result held until completion, done after 2 cycles
        launch(8'd3, 8'd4, 1'b0, 1'b0);
        chk("add1.busy0", 32'(busy), 32'd1);
        chk("add1.done0", 32'(done), 32'd0);
        tick();
        chk("add1.done1", 32'(done), 32'd0);
        chk("add1.hold",  32'(out),  32'h00);
        tick();
        res("add1", 8'h07, 1'b0, 1'b0);
        tick();
        chk("add1.pulse", 32'(done), 32'd0);

        // 0xFF + 0xFF
        launch(8'hFF, 8'hFF, 1'b0, 1'b0);
        tick(); tick();
        res("add2", 8'hFE, 1'b1, 1'b0);
        tick();

        // 5 - 7
        launch(8'd5, 8'd7, 1'b1, 1'b0);
        tick(); tick();
        res("sub1", 8'hFE, 1'b0, 1'b0);
        tick();

        // 0x80 - 0x01, then accumulate +1 issued in the done cycle
        launch(8'h80, 8'h01, 1'b1, 1'b0);
        tick(); tick();
        res("sub2", 8'h7F, 1'b1, 1'b1);
        launch(8'h55, 8'h01, 1'b0, 1'b1);
        chk("acc.busy0", 32'(busy), 32'd1);
        tick();
        chk("acc.hold", 32'(out), 32'h7F);
        tick();
        res("acc", 8'h80, 1'b0, 1'b1);
        acc = 0;
        tick();

        // start held while busy is ignored
        in_a = 8'h10; in_b = 8'h20; sub = 0; start = 1;
        tick();
        in_a = 8'hAA; in_b = 8'h11;
        tick();
        start = 0;
        chk("ign.busy", 32'(busy), 32'd1);
        chk("ign.done", 32'(done), 32'd0);
        tick();
        res("ign", 8'h30, 1'b0, 1'b0);
        tick();
        chk("ign.single", 32'(done), 32'd0);
        chk("ign.idle",   32'(busy), 32'd0);
        chk("ign.out",    32'(out),  32'h30);

        // rst mid-RUN aborts asynchronously; start held through rst is ignored
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        in_a = 8'd2; in_b = 8'd3; start = 1;
        #1 rst = 1;
        #1;
        chk("arst.out",  32'(out),  32'h00);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        tick();
        chk("arst.nobusy", 32'(busy), 32'd0);
        chk("arst.nodone", 32'(done), 32'd0);
        chk("arst.out2",   32'(out),  32'h00);
        rst = 0;
        tick();
        start = 0;
        chk("arst.accept", 32'(busy), 32'd1);
        tick();
        chk("arst.nodone2", 32'(done), 32'd0);
        tick();
        res("arst.op", 8'h05, 1'b0, 1'b0);

        // WIDTH=4 CHUNK=1: 15 + 15, done exactly 4 cycles after start
        s4_a = 4'hF; s4_b = 4'hF; s4_start = 1;
        tick();
        s4_start = 0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("w4.early%0d", i), 32'(s4_done), 32'd0);
        end
        tick();
        chk("w4.done", 32'(s4_done), 32'd1);
        chk("w4.out",  32'(s4_out),  32'hE);
        chk("w4.cout", 32'(s4_cout), 32'd1);
        chk("w4.ovf",  32'(s4_ovf),  32'd0);

        // WIDTH=CHUNK=8: latency 1
        s8_a = 8'h7F; s8_b = 8'h01; s8_start = 1;
        tick();
        s8_start = 0;
        chk("w8.busy", 32'(s8_busy), 32'd1);
        tick();
        chk("w8.done", 32'(s8_done), 32'd1);
        chk("w8.out",  32'(s8_out),  32'h80);
        chk("w8.cout", 32'(s8_cout), 32'd0);
        chk("w8.ovf",  32'(s8_ovf),  32'd1);
        tick();
        chk("w8.pulse", 32'(s8_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_acc_n_bit.md
ADDER_ACC_N_BIT -- requirements
Module: adder_acc_n_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port sub  input  1  0 = in_a + in_b, 1 = in_a - in_b.
REQ-007 The block SHALL have port acc  input  1  1 = use current out in place of in_a (accumulate).
REQ-008 The block SHALL have port in_a  input  WIDTH  operand A.
REQ-009 The block SHALL have port in_b  input  WIDTH  operand B.
REQ-010 The block SHALL have port out  output  WIDTH  last completed result.
REQ-011 The block SHALL have port cout  output  1  carry out of MSB of last result (sub: 1 = no borrow).
REQ-012 The block SHALL have port ovf  output  1  two's-complement overflow of last result.
REQ-013 The block SHALL have port busy  output  1  operation in progress.
REQ-014 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 The block SHALL implement two states: IDLE and RUN.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture in_a (or out if acc=1), in_b (inverted if sub=1), sub, carry-in = sub, set chunk index 0, and enter RUN; busy=1 from that edge.
REQ-017 In RUN, each rising edge SHALL add one CHUNK-bit slice, LSB slice first, propagating the slice carry to the next slice.
REQ-018 After the NCH-th RUN edge the block SHALL load out, cout, ovf, pulse done=1 for exactly one cycle, clear busy and return to IDLE; latency start-edge to done = NCH cycles.
REQ-019 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-020 out, cout, ovf SHALL hold the previous result unchanged while busy=1 and until the next completion.
REQ-021 start while busy=1 SHALL be ignored with no effect on the running operation.
REQ-022 start asserted in the cycle done=1 SHALL be accepted (busy is 0); acc=1 then uses the just-completed out.
REQ-023 Results SHALL wrap modulo 2^WIDTH; no saturation.
REQ-024 Operand inputs SHALL be don't-care after the capture edge.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, out=0, cout=0, ovf=0, busy=0, done=0, chunk index 0, independent of clk.
REQ-026 rst asserted during RUN SHALL abort the operation; no done pulse and no result update SHALL follow.
REQ-027 start held during rst SHALL be ignored; first acceptance is the first rising edge with rst=0.

Verification (WIDTH=8, CHUNK=4, NCH=2 unless stated)
REQ-028 Reset: rst pulse -> out=0x00, cout=0, ovf=0, busy=0, done=0.
REQ-029 Add: in_a=3, in_b=4, sub=0, start one cycle -> 2 cycles later out=0x07, cout=0, ovf=0, done high one cycle; in_a=0xFF, in_b=0xFF -> out=0xFE, cout=1, ovf=0.
REQ-030 Subtract: in_a=5, in_b=7, sub=1 -> out=0xFE, cout=0, ovf=0; in_a=0x80, in_b=0x01, sub=1 -> out=0x7F, cout=1, ovf=1.
REQ-031 Accumulate back-to-back: after out=0x7F, start with acc=1, in_b=0x01, sub=0 in the done cycle -> out=0x80, cout=0, ovf=1, two cycles later.
REQ-032 Protocol: start re-asserted while busy -> ignored, single done, result of first operation only; rst during RUN -> no done, out=0x00.
REQ-033 Parameter sweep: WIDTH=4, CHUNK=1, in_a=15, in_b=15 -> done 4 cycles after start, out=0xE, cout=1, ovf=0; WIDTH=CHUNK=8 -> latency 1.
